// File: rtl/cpu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// Shared definitions for the 9-bit single-accumulator CPU sequencer.
//
// ControlUnit_def : the opcode and function-field encodings that the ControlUnit
//                   decoder uses. The sequencer only needs the values that
//                   identify HALT.
// Sequencer_def   : the sequencer state type, the HALT match constants and a
//                   helper that recognises a HALT instruction word.
//
// Instruction word layout used here: [8:6] opcode, [1:0] function field.
// -----------------------------------------------------------------------------
package ControlUnit_def;

    typedef enum logic [2:0] {
        R_ADD    = 3'b000,
        R_LOAD   = 3'b001,
        R_STORE  = 3'b010,
        R_BRANCH = 3'b011,
        R_NEG    = 3'b111
    } Opcode;

    localparam logic [1:0] FUN_HALT = 2'b11;

endpackage : ControlUnit_def

package Sequencer_def;

    import ControlUnit_def::*;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        HALTED = 3'd5
    } SeqState;

    localparam logic [2:0] HALT_OPCODE = R_NEG;
    localparam logic [1:0] HALT_FUNCT  = FUN_HALT;

    // HALT shares the R_NEG opcode and is told apart by its function field.
    function automatic logic is_halt(input logic [8:0] insn);
        return (insn[8:6] == HALT_OPCODE) && (insn[1:0] == HALT_FUNCT);
    endfunction

endpackage : Sequencer_def

// File: rtl/cpu_sequencer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter: W-bit up-counter with synchronous clear that stops at all-ones.
//
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-high reset (count -> 0)
//   i_clear  in   synchronous clear, wins over i_enable
//   i_enable in   count up by one this cycle unless already saturated
//   o_count  out  current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_enable,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule : sat_counter

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer: multi-cycle fetch/decode/execute sequencer for the 9-bit
// single-accumulator CPU. Owns the PC, fetches from the synchronous
// instruction ROM, holds the instruction register feeding the ControlUnit,
// and gates the decoder's write/read strobes so each instruction commits once.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             begin execution (honoured only in IDLE / HALTED)
//   imem_addr         instruction ROM address (= pc)
//   imem_data         ROM data, valid one cycle after imem_addr
//   instruction       instruction register, to the ControlUnit decoder
//   ctrl_*            decoder requests for the current instruction
//   take_branch       decoder: branch condition true
//   branch_target     absolute branch target, zero-extended to PC_W
//   reg_we/mem_we     gated single-cycle write strobes
//   mem_re            gated data-memory read enable (held through MEM)
//   pc                current program counter
//   done              high while HALTED
//   cycle_count       active cycles since the last start, saturating
//
// Timing: FETCH, DECODE, EXEC = 3 cycles per instruction; loads add MEM_LAT
// MEM cycles, the last of which commits the register write.
// -----------------------------------------------------------------------------
module cpu_sequencer
    import Sequencer_def::*;
#(
    parameter int PC_W     = 10,
    parameter int MEM_LAT  = 1,
    parameter int START_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_data,
    output logic [8:0]      instruction,
    input  logic            ctrl_reg_write,
    input  logic            ctrl_mem_read,
    input  logic            ctrl_mem_write,
    input  logic            ctrl_branch,
    input  logic            take_branch,
    input  logic [7:0]      branch_target,
    output logic            reg_we,
    output logic            mem_we,
    output logic            mem_re,
    output logic [PC_W-1:0] pc,
    output logic            done,
    output logic [15:0]     cycle_count
);

    // Wide enough to hold MEM_LAT-1, never narrower than one bit.
    localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT  = WAIT_W'(MEM_LAT - 1);
    localparam logic [PC_W-1:0]   START_ADDR = PC_W'(START_PC);

    SeqState           r_state;
    logic [PC_W-1:0]   r_pc;
    logic [8:0]        r_instruction;
    logic              r_done;
    logic [WAIT_W-1:0] r_wait;

    logic              w_is_halt;
    logic              w_exec_commit;
    logic              w_exec_load;
    logic              w_mem_last;
    logic              w_start_accept;
    logic              w_active;
    logic [PC_W-1:0]   w_next_pc;

    assign w_is_halt = is_halt(r_instruction);

    // EXEC either halts, hands off to MEM for a load, or commits directly.
    assign w_exec_load   = (r_state == EXEC) && !w_is_halt && ctrl_mem_read;
    assign w_exec_commit = (r_state == EXEC) && !w_is_halt && !ctrl_mem_read;
    assign w_mem_last    = (r_state == MEM) && (r_wait == '0);

    assign w_start_accept = start && ((r_state == IDLE) || (r_state == HALTED));
    assign w_active       = (r_state == FETCH) || (r_state == DECODE) ||
                            (r_state == EXEC)  || (r_state == MEM);

    // pc+1 wraps naturally in PC_W bits; the 8-bit target is zero-extended.
    assign w_next_pc = (ctrl_branch && take_branch) ? PC_W'(branch_target)
                                                    : r_pc + PC_W'(1);

    // Strobes are decoded from state so an async reset drops them at once.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave a value held and infer a latch.
    always_comb begin
        reg_we = 1'b0;
        mem_we = 1'b0;
        mem_re = 1'b0;
        if (w_exec_commit) begin
            reg_we = ctrl_reg_write;
            mem_we = ctrl_mem_write;
        end
        if (w_mem_last) begin
            reg_we = ctrl_reg_write;
        end
        if (w_exec_load || (r_state == MEM)) begin
            mem_re = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= START_ADDR;
            r_instruction <= '0;
            r_done        <= 1'b0;
            r_wait        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FETCH;
                        r_pc    <= START_ADDR;
                    end
                end
                FETCH: begin
                    r_state <= DECODE;
                end
                DECODE: begin
                    // ROM data for the address presented in FETCH is valid now.
                    r_instruction <= imem_data;
                    r_state       <= EXEC;
                end
                EXEC: begin
                    if (w_is_halt) begin
                        r_state <= HALTED;
                        r_done  <= 1'b1;
                    end else if (ctrl_mem_read) begin
                        r_wait  <= WAIT_INIT;
                        r_state <= MEM;
                    end else begin
                        r_pc    <= w_next_pc;
                        r_state <= FETCH;
                    end
                end
                MEM: begin
                    if (r_wait != '0) begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end else begin
                        r_pc    <= w_next_pc;
                        r_state <= FETCH;
                    end
                end
                HALTED: begin
                    if (start) begin
                        r_state <= FETCH;
                        r_pc    <= START_ADDR;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Cleared on the accepted start edge, counts every active cycle after.
    sat_counter #(
        .W (16)
    ) u_cycle_count (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_start_accept),
        .i_enable (w_active),
        .o_count  (cycle_count)
    );

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instruction = r_instruction;
    assign done        = r_done;

endmodule : cpu_sequencer

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for cpu_sequencer (PC_W=10, MEM_LAT=2, START_PC=0). A ROM array and a
// toy decoder surround the DUT. Expected per-cycle behaviour for random
// programs comes from an instruction-level model using the latency rules
// (3 cycles, or 3+MEM_LAT for loads).
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

    localparam int PC_W     = 10;
    localparam int MEM_LAT  = 2;
    localparam int START_PC = 0;
    localparam int ROM_N    = 1 << PC_W;
    localparam int MAXC     = 400;

    localparam logic [8:0] I_ADD   = 9'b000_000_001;
    localparam logic [8:0] I_LOAD  = 9'b001_000_000;
    localparam logic [8:0] I_STORE = 9'b010_000_000;
    localparam logic [8:0] I_BN    = 9'b100_000_000;
    localparam logic [8:0] I_NEG   = 9'b111_000_000;
    localparam logic [8:0] I_HALT  = 9'b111_000_011;

    logic            clk;
    logic            reset;
    logic            start;
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      imem_data;
    logic [8:0]      instruction;
    logic            ctrl_reg_write, ctrl_mem_read, ctrl_mem_write;
    logic            ctrl_branch, take_branch;
    logic [7:0]      branch_target;
    logic            reg_we, mem_we, mem_re;
    logic [PC_W-1:0] pc;
    logic            done;
    logic [15:0]     cycle_count;

    logic [8:0] rom [ROM_N];
    int n_cmp;
    int n_fail;
    int cyc;

    bit exp_rw [MAXC+2];
    bit exp_mw [MAXC+2];
    bit exp_mr [MAXC+2];
    int exp_pc [MAXC+2];

    typedef struct {
        logic start;
        logic reg_we;
        logic done;
        int   pc;
        int   cnt;
    } vec_t;
    vec_t tbl [14];

    cpu_sequencer #(
        .PC_W     (PC_W),
        .MEM_LAT  (MEM_LAT),
        .START_PC (START_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instruction    (instruction),
        .ctrl_reg_write (ctrl_reg_write),
        .ctrl_mem_read  (ctrl_mem_read),
        .ctrl_mem_write (ctrl_mem_write),
        .ctrl_branch    (ctrl_branch),
        .take_branch    (take_branch),
        .branch_target  (branch_target),
        .reg_we         (reg_we),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .pc             (pc),
        .done           (done),
        .cycle_count    (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction ROM.
    always @(posedge clk) imem_data <= rom[imem_addr];

    // Toy decoder. HALT deliberately raises every request so the DUT must gate them.
    always_comb begin
        ctrl_reg_write = 1'b0;
        ctrl_mem_read  = 1'b0;
        ctrl_mem_write = 1'b0;
        ctrl_branch    = 1'b0;
        take_branch    = 1'b0;
        branch_target  = {instruction[5:0], 2'b00};
        case (instruction[8:6])
            3'b000: ctrl_reg_write = 1'b1;
            3'b001: begin ctrl_mem_read = 1'b1; ctrl_reg_write = 1'b1; end
            3'b010: ctrl_mem_write = 1'b1;
            3'b011: begin ctrl_branch = 1'b1; take_branch = 1'b1; end
            3'b100: ctrl_branch = 1'b1;
            3'b111: begin
                ctrl_reg_write = 1'b1;
                if (instruction[1:0] == 2'b11) begin
                    ctrl_mem_read  = 1'b1;
                    ctrl_mem_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    function automatic logic [8:0] bt(input int target);
        return {3'b011, 6'(target >> 2)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic launch();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Instruction-level model: walks the ROM and lays out per-cycle expectations.
    task automatic build_model(output int hc, output int hpc);
        int pc_m, t, len;
        logic [8:0] ins;
        logic [2:0] op;
        for (int c = 0; c <= MAXC + 1; c++) begin
            exp_rw[c] = 1'b0; exp_mw[c] = 1'b0; exp_mr[c] = 1'b0; exp_pc[c] = 0;
        end
        pc_m = START_PC; t = 1; hc = 0; hpc = 0;
        while (hc == 0 && t < MAXC - 10) begin
            ins = rom[pc_m];
            op  = ins[8:6];
            if (op == 3'b111 && ins[1:0] == 2'b11) begin
                for (int k = 0; k < 3; k++) exp_pc[t+k] = pc_m;
                hc  = t + 3;
                hpc = pc_m;
            end else begin
                len = (op == 3'b001) ? 3 + MEM_LAT : 3;
                for (int k = 0; k < len; k++) exp_pc[t+k] = pc_m;
                if (op == 3'b000 || op == 3'b001 || op == 3'b111) exp_rw[t+len-1] = 1'b1;
                if (op == 3'b010) exp_mw[t+2] = 1'b1;
                if (op == 3'b001) for (int k = 2; k < len; k++) exp_mr[t+k] = 1'b1;
                pc_m = (op == 3'b011) ? int'({ins[5:0], 2'b00}) : (pc_m + 1) % ROM_N;
                t += len;
            end
        end
        if (hc == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL model_bound: program did not reach HALT within %0d cycles", MAXC);
        end
    endtask

    // Forward-only random program in 0..59 ending at a HALT at address 60.
    task automatic gen_program();
        for (int a = 0; a < 64; a++) rom[a] = I_ADD;
        for (int a = 0; a < 60; a++) begin
            case ($urandom_range(0, 5))
                0: rom[a] = I_ADD;
                1: rom[a] = I_LOAD;
                2: rom[a] = I_STORE;
                3: rom[a] = bt(4 * int'($urandom_range(a / 4 + 1, 15)));
                4: rom[a] = I_BN;
                default: rom[a] = I_NEG;
            endcase
        end
        rom[60] = I_HALT;
    endtask

    task automatic run_random(input int run);
        int hc, hpc;
        string p;
        gen_program();
        build_model(hc, hpc);
        if (hc == 0) return;
        launch();
        for (int c = 1; c <= hc + 1; c++) begin
            step_to(c);
            p = $sformatf("rnd%0d_c%0d", run, c);
            if (c < hc) begin
                check({p, "_pc"},     32'(imem_addr),   32'(exp_pc[c]));
                check({p, "_reg_we"}, 32'(reg_we),      32'(exp_rw[c]));
                check({p, "_mem_we"}, 32'(mem_we),      32'(exp_mw[c]));
                check({p, "_mem_re"}, 32'(mem_re),      32'(exp_mr[c]));
                check({p, "_done"},   32'(done),        32'd0);
                check({p, "_count"},  32'(cycle_count), 32'(c - 1));
            end else begin
                check({p, "_pc"},     32'(pc),          32'(hpc));
                check({p, "_strobe"}, {29'd0, reg_we, mem_we, mem_re}, 32'd0);
                check({p, "_done"},   32'(done),        32'd1);
                check({p, "_count"},  32'(cycle_count), 32'(hc - 1));
            end
            // Stray start pulses while running must be ignored.
            start = (c < hc) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0;
        reset = 1'b1;
        start = 1'b0;
        for (int a = 0; a < ROM_N; a++) rom[a] = I_ADD;

        // Three ADDs then HALT; stray start during the first EXEC.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 0, 1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 0, 2};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1, 3};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1, 4};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1, 5};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 2, 6};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 2, 7};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 2, 8};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 3, 9};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 3, 10};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 3, 11};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 3, 12};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 3, 12};

        // Reset state.
        #12;
        check("rst_pc",     32'(pc),          32'd0);
        check("rst_addr",   32'(imem_addr),   32'd0);
        check("rst_insn",   32'(instruction), 32'd0);
        check("rst_done",   32'(done),        32'd0);
        check("rst_count",  32'(cycle_count), 32'd0);
        check("rst_strobe", {29'd0, reg_we, mem_we, mem_re}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_done",  32'(done),        32'd0);
        check("idle_count", 32'(cycle_count), 32'd0);

        // Table-driven program.
        rom[3] = I_HALT;
        for (int i = 0; i < 14; i++) begin
            start = tbl[i].start;
            @(negedge clk);
            check($sformatf("tbl%0d_reg_we", i), 32'(reg_we),      32'(tbl[i].reg_we));
            check($sformatf("tbl%0d_mem", i),    {30'd0, mem_we, mem_re}, 32'd0);
            check($sformatf("tbl%0d_done", i),   32'(done),        32'(tbl[i].done));
            check($sformatf("tbl%0d_pc", i),     32'(imem_addr),   32'(tbl[i].pc));
            check($sformatf("tbl%0d_count", i),  32'(cycle_count), 32'(tbl[i].cnt));
        end
        start = 1'b0;

        // Load at pc=4 with MEM_LAT=2, then a taken branch at pc=5 to 0x20.
        for (int a = 0; a < 4; a++) rom[a] = I_ADD;
        rom[4] = I_LOAD;
        rom[5] = bt(32'h20);
        rom[32'h20] = I_HALT;
        check("halted_done", 32'(done), 32'd1);
        launch();
        check("restart_done", 32'(done),        32'd0);
        check("restart_pc",   32'(imem_addr),   32'(START_PC));
        check("restart_cnt",  32'(cycle_count), 32'd0);
        step_to(14); check("ld_d_mem_re", 32'(mem_re), 32'd0);
        step_to(15); check("ld_e_mem_re", 32'(mem_re), 32'd1); check("ld_e_reg_we", 32'(reg_we), 32'd0);
        check("ld_e_pc", 32'(pc), 32'd4);
        step_to(16); check("ld_m1_mem_re", 32'(mem_re), 32'd1); check("ld_m1_reg_we", 32'(reg_we), 32'd0);
        step_to(17); check("ld_m2_mem_re", 32'(mem_re), 32'd1); check("ld_m2_reg_we", 32'(reg_we), 32'd1);
        step_to(18); check("ld_ret_mem_re", 32'(mem_re), 32'd0); check("ld_ret_pc", 32'(imem_addr), 32'd5);
        step_to(21); check("bt_target", 32'(imem_addr), 32'h020);
        step_to(24);
        check("bt_done",  32'(done),        32'd1);
        check("bt_count", 32'(cycle_count), 32'd23);
        check("bt_insn",  32'(instruction), 32'(I_HALT));

        // Untaken branch at pc=5 falls through to 6.
        rom[5] = I_BN;
        rom[6] = I_HALT;
        launch();
        step_to(20); check("bn_exec_strobe", {29'd0, reg_we, mem_we, mem_re}, 32'd0);
        step_to(21); check("bn_next", 32'(imem_addr), 32'h006);
        step_to(24); check("bn_done", 32'(done), 32'd1);

        // Reset asserted during EXEC of a store.
        rom[0] = I_ADD;
        rom[1] = I_STORE;
        rom[2] = I_HALT;
        launch();
        step_to(6);
        check("st_mem_we", 32'(mem_we), 32'd1);
        check("st_reg_we", 32'(reg_we), 32'd0);
        check("st_pc",     32'(pc),     32'd1);
        reset = 1'b1;
        #1;
        check("rstx_strobe", {29'd0, reg_we, mem_we, mem_re}, 32'd0);
        check("rstx_pc",     32'(pc),          32'd0);
        check("rstx_count",  32'(cycle_count), 32'd0);
        check("rstx_insn",   32'(instruction), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rstx_idle_pc",    32'(pc),          32'd0);
        check("rstx_idle_count", 32'(cycle_count), 32'd0);
        check("rstx_idle_we",    {30'd0, reg_we, mem_we}, 32'd0);

        // Random programs against the model (first from IDLE, rest from HALTED).
        for (int r = 0; r < 8; r++) run_random(r);

        // PC wrap from 0x3FF to 0x000; address 0 becomes HALT once fetched.
        for (int a = 0; a < ROM_N; a++) rom[a] = I_ADD;
        launch();
        step_to(5);
        rom[0] = I_HALT;
        step_to(3070); check("wrap_top",    32'(imem_addr), 32'h3FF);
        step_to(3072); check("wrap_reg_we", 32'(reg_we),    32'd1);
        step_to(3073); check("wrap_zero",   32'(imem_addr), 32'h000);
        step_to(3076);
        check("wrap_done",  32'(done),        32'd1);
        check("wrap_count", 32'(cycle_count), 32'd3075);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_cpu_sequencer

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle fetch/execute sequencer for the 9-bit single-accumulator CPU. It owns the program counter, fetches from the synchronous instruction ROM, and latches the instruction register that feeds the combinational ControlUnit decoder. It gates the decoder's register-file and data-memory write strobes so each instruction commits exactly once. It also handles branches, data-memory read latency, halt and start/done handshaking with the testbench or host.

Parameters:
PC_W, 10, program counter / instruction ROM address width
MEM_LAT, 1, data-memory read latency in cycles (>=1)
START_PC, 0, PC value loaded on start

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  begin execution; sampled only in IDLE/HALTED
imem_addr  out  PC_W  instruction ROM address (= pc)
imem_data  in  9  ROM data, valid one cycle after imem_addr
instruction  out  9  instruction register, to ControlUnit
ctrl_reg_write  in  1  decoder register write request
ctrl_mem_read  in  1  decoder data-memory read request
ctrl_mem_write  in  1  decoder data-memory write request
ctrl_branch  in  1  decoder: instruction is a branch
take_branch  in  1  decoder: branch condition true
branch_target  in  8  absolute target (LUT output), zero-extended to PC_W
reg_we  out  1  gated register-file write enable
mem_we  out  1  gated data-memory write enable
mem_re  out  1  gated data-memory read enable
pc  out  PC_W  current program counter
done  out  1  high while HALTED
cycle_count  out  16  active cycles since start, saturating

Behaviour:
- Reset (async, immediate): state=IDLE, pc=START_PC, instruction=0, reg_we=mem_we=mem_re=0, done=0, cycle_count=0. Reset mid-instruction aborts with no further strobe.
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALTED (enum SeqState).
- IDLE: start=1 -> FETCH; pc<=START_PC; cycle_count<=0.
- FETCH: imem_addr=pc. Next state DECODE.
- DECODE: imem_data valid. instruction<=imem_data at end of cycle. Next state EXEC.
- EXEC: decoder outputs are valid this cycle.
  - Halt is instruction[8:6]==R_NEG and instruction[1:0]==FUN_HALT. On halt: no strobes; next state HALTED; pc unchanged.
  - If ctrl_mem_read: mem_re=1; next state MEM with wait counter=MEM_LAT-1.
  - Otherwise: reg_we=ctrl_reg_write and mem_we=ctrl_mem_write for this single cycle; pc update; next state FETCH.
- MEM: mem_re=1 held. While counter!=0, decrement. When counter==0: reg_we=ctrl_reg_write (one cycle), pc update, next state FETCH.
- PC update: if ctrl_branch && take_branch, pc<=branch_target; else pc<=pc+1, wrapping modulo 2^PC_W.
- Strobes are combinational from state and ctrl inputs. They are never high outside EXEC/MEM, and each is at most one cycle per instruction (mem_re excepted).
- Latency: 3 cycles for non-load instructions; 3+MEM_LAT cycles for loads.
- HALTED: done=1 held. start=1 -> FETCH at START_PC, done<=0 on the same edge, cycle_count cleared.
- start is ignored in FETCH/DECODE/EXEC/MEM.
- cycle_count increments on every clk in FETCH/DECODE/EXEC/MEM and saturates at 0xFFFF.
- instruction holds its value in HALTED and IDLE.

Decomposition:
- Package Sequencer_def holds: typedef enum logic[2:0] SeqState, and the HALT match constants, reusing Opcode R_NEG and FUN_HALT from ControlUnit_def.
- One sub-module, sat_counter (16-bit saturating counter with clear/enable), for cycle_count.
- The rest is a single FSM module.

Test Plan:
- Reset mid-EXEC of a store: assert reset -> reg_we=mem_we=0 within the same cycle, state IDLE, pc=0, cycle_count=0.
- ROM 0..2 = three ADDs, then HALT; pulse start -> reg_we high exactly at cycles 3, 6 and 9; done=1 from cycle 13; cycle_count=12.
- Load with MEM_LAT=2 at pc=4 -> mem_re high for 3 cycles, reg_we single cycle in the last MEM cycle, pc=5 on return to FETCH.
- Taken branch at pc=5 with branch_target=0x20 -> next imem_addr=0x020. Untaken branch -> 0x006.
- pc=0x3FF with a non-branch instruction -> pc wraps to 0x000.
- HALTED then start=1 -> done falls on the next edge and fetch resumes at START_PC. start pulsed during EXEC -> no effect.
